// File: rtl/booth_mult_pkg.sv
// booth_mult_pkg: shared types and constants for the Booth multiplier sequencer
package booth_mult_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int SETTLE_W = 4;
    typedef enum logic [2:0] {INIT, IDLE, LOAD, SETTLE, CAPTURE, RESULT} state_t;
endpackage

// File: rtl/booth_settle_counter.sv
// booth_settle_counter: loadable down-counter timing the multiplier settle window
module booth_settle_counter
    import booth_mult_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [SETTLE_W-1:0] load_val,
    output logic [SETTLE_W-1:0] count,
    output logic                done
);
    // Load on request, otherwise count down and park at zero
    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - SETTLE_W'(1);
    end
    assign done = count == SETTLE_W'(1);
endmodule

// File: rtl/booth_mult_sequencer.sv
// booth_mult_sequencer: handshake front end that times the registered Booth multiplier
module booth_mult_sequencer
    import booth_mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product,
    output logic               busy,
    output logic [15:0]        op_count,
    output logic [WIDTH-1:0]   Multiplicand,
    output logic [WIDTH-1:0]   Multiplier,
    output logic               enableA,
    output logic               enableB,
    output logic               enableOut,
    output logic               resetA,
    output logic               resetB,
    output logic               resetOut,
    input  logic [2*WIDTH-1:0] Product
);
    localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE_CYCLES);
    state_t state, state_nxt;
    logic [SETTLE_W-1:0] cnt, cnt_nxt;
    logic cnt_done, accept, handshake, en_out_nxt;
    booth_settle_counter u_cnt (
        .clk     (clk),
        .reset   (reset),
        .load    (state == LOAD),
        .load_val(SETTLE_LD),
        .count   (cnt),
        .done    (cnt_done)
    );
    // Next state, plus the output-register enable which must lead CAPTURE by one
    // cycle so the output register holds the fresh product when RESULT samples it
    always_comb begin
        state_nxt = state;
        accept = state == IDLE && in_valid && in_ready;
        handshake = state == RESULT && out_valid && out_ready;
        cnt_nxt = state == LOAD ? SETTLE_LD : cnt - SETTLE_W'(1);
        unique case (state)
            INIT:    state_nxt = IDLE;
            IDLE:    state_nxt = accept ? LOAD : IDLE;
            LOAD:    state_nxt = SETTLE_CYCLES > 0 ? SETTLE : CAPTURE;
            SETTLE:  state_nxt = cnt_done ? CAPTURE : SETTLE;
            CAPTURE: state_nxt = RESULT;
            RESULT:  state_nxt = handshake ? IDLE : RESULT;
            default: state_nxt = INIT;
        endcase
        en_out_nxt = state_nxt == CAPTURE || (state_nxt == SETTLE && cnt_nxt == SETTLE_W'(1));
    end
    // State register and every registered output
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= INIT;
            resetA       <= 1'b1;
            resetB       <= 1'b1;
            resetOut     <= 1'b1;
            enableA      <= 1'b0;
            enableB      <= 1'b0;
            enableOut    <= 1'b0;
            in_ready     <= 1'b0;
            out_valid    <= 1'b0;
            out_product  <= '0;
            Multiplicand <= '0;
            Multiplier   <= '0;
            op_count     <= '0;
            busy         <= 1'b1;
        end else begin
            state     <= state_nxt;
            resetA    <= 1'b0;
            resetB    <= 1'b0;
            resetOut  <= 1'b0;
            enableA   <= accept;
            enableB   <= accept;
            enableOut <= en_out_nxt;
            in_ready  <= state_nxt == IDLE;
            out_valid <= state_nxt == RESULT;
            busy      <= state_nxt != IDLE;
            if (state != RESULT && state_nxt == RESULT)
                out_product <= Product;
            if (accept) begin
                Multiplicand <= in_a;
                Multiplier   <= in_b;
            end
            if (handshake)
                op_count <= op_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_booth_mult_sequencer.sv
// tb_booth_mult_sequencer: directed checks of the sequencer driving a registered multiplier model
module tb_booth_mult_sequencer;
    localparam int W = 32;
    localparam int S = 2;
    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
    } vec_t;
    logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic [W-1:0] in_a = '0, in_b = '0;
    logic in_ready, out_valid, busy, enableA, enableB, enableOut, resetA, resetB, resetOut;
    logic [2*W-1:0] out_product, Product;
    logic [15:0] op_count;
    logic [W-1:0] Multiplicand, Multiplier;
    logic signed [W-1:0] ma, mb;
    int cyc = 0, passed = 0, total = 0;
    vec_t vecs[3];
    booth_mult_sequencer #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_product(out_product), .busy(busy), .op_count(op_count),
        .Multiplicand(Multiplicand), .Multiplier(Multiplier),
        .enableA(enableA), .enableB(enableB), .enableOut(enableOut),
        .resetA(resetA), .resetB(resetB), .resetOut(resetOut), .Product(Product)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // Registered Booth multiplier stand-in: input registers then output register
    always_ff @(posedge clk) begin
        if (resetA) ma <= '0; else if (enableA) ma <= Multiplicand;
        if (resetB) mb <= '0; else if (enableB) mb <= Multiplier;
        if (resetOut) Product <= '0; else if (enableOut) Product <= 64'(ma) * 64'(mb);
    end
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
        else passed++;
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, output int acc);
        int n = 0;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("accept_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        acc = cyc;
        in_valid = 1'b0;
    endtask
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 60) begin
            tick();
            n++;
        end
        chk("valid_seen", 64'(out_valid), 64'(1));
    endtask
    initial begin
        int acc, prev, n;
        logic ok, seen;
        vecs[0] = '{32'd32, 32'd23, 64'd736};
        vecs[1] = '{32'd1234, 32'd0, 64'd0};
        vecs[2] = '{32'd99, 32'd1, 64'd99};
        repeat (3) tick();
        chk("rst_ctl", 64'({resetA, resetB, resetOut, in_ready, busy, out_valid, enableA, enableB, enableOut}), 64'(9'b111_0_1_0_000));
        chk("rst_count", 64'(op_count), 64'(0));
        chk("rst_prod", out_product, 64'(0));
        chk("rst_ops", {Multiplicand, Multiplier}, 64'(0));
        reset = 1'b0;
        chk("init_ctl", 64'({resetA, resetB, resetOut, in_ready}), 64'(4'b1110));
        tick();
        chk("idle_ctl", 64'({resetA, resetB, resetOut, in_ready, busy}), 64'(5'b00010));
        out_ready = 1'b1;
        send(32'd5, 32'd6, acc);
        chk("busy_op", 64'(busy), 64'(1));
        wait_valid(n);
        chk("latency", 64'(n + 1), 64'(S + 3));
        chk("prod_5x6", out_product, 64'd30);
        tick();
        chk("valid_drop", 64'(out_valid), 64'(0));
        chk("count_1", 64'(op_count), 64'(1));
        out_ready = 1'b0;
        send(-4, -7, acc);
        wait_valid(n);
        chk("prod_n4xn7", out_product, 64'd28);
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            ok &= out_valid && out_product == 64'd28;
        end
        chk("stall_stable", 64'(ok), 64'(1));
        out_ready = 1'b1;
        tick();
        chk("stall_release", 64'(out_valid), 64'(0));
        chk("count_2", 64'(op_count), 64'(2));
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen |= out_valid;
        end
        chk("no_second_pulse", 64'(seen), 64'(0));
        send(-50, 32'd5, acc);
        in_a = 32'd99;
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        chk("ignored_a", 64'(Multiplicand), 64'(32'hFFFF_FFCE));
        wait_valid(n);
        chk("prod_n50x5", out_product, 64'hFFFF_FFFF_FFFF_FF06);
        tick();
        chk("count_3", 64'(op_count), 64'(3));
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen |= busy;
        end
        chk("no_extra_op", 64'(seen), 64'(0));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("count_cleared", 64'(op_count), 64'(0));
        tick();
        prev = 0;
        for (int i = 0; i < 3; i++) begin
            send(vecs[i].a, vecs[i].b, acc);
            if (i > 0) chk("spacing", 64'(acc - prev), 64'(S + 4));
            prev = acc;
            wait_valid(n);
            chk("b2b_prod", out_product, vecs[i].p);
        end
        tick();
        chk("b2b_count", 64'(op_count), 64'(3));
        send(32'd10, -4, acc);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_ctl", 64'({out_valid, resetA, busy}), 64'(3'b011));
        chk("midrst_count", 64'(op_count), 64'(0));
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            seen |= out_valid;
        end
        chk("midrst_no_result", 64'(seen), 64'(0));
        send(32'd10, -4, acc);
        wait_valid(n);
        chk("prod_10xn4", out_product, 64'hFFFF_FFFF_FFFF_FFD8);
        tick();
        chk("recover_count", 64'(op_count), 64'(1));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
